// File: rtl/beat_pkg.sv
// Shared types and helpers for the machine-cycle beat generator.
package beat_pkg;

   // Beat sequencer states; W1..W3 map one-to-one onto the beat outputs.
   typedef enum logic [1:0] {
      B_IDLE,
      B_W1,
      B_W2,
      B_W3
   } beat_state_t;

   // Largest beat length the tick counter is designed for.
   localparam int TICKS_MAX = 16;

   // Tick counter width for a given beat length. A floor of 2 keeps the
   // counter at least one bit wide when every beat is a single tick.
   function automatic int tick_width(input int ticks);
      return $clog2((ticks < 2) ? 2 : ticks);
   endfunction

endpackage

// File: rtl/beat_gen_rise_detect.sv
// Single-cycle pulse on a rising edge of a panel switch level.
module rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic pulse
);

   logic d_q;

   // Remember last cycle's level; cleared in reset so a level that is
   // already high when reset lifts reads as a fresh edge.
   always_ff @(posedge clk) begin
      if (!rst_n) d_q <= 1'b0;
      else        d_q <= d;
   end

   assign pulse = d & ~d_q;

endmodule

// File: rtl/beat_gen.sv
// Machine-cycle beat generator driving W1/W2/W3 into the hardwired
// controller. Cycle length follows the controller's short/long requests,
// sequencing starts on a QD press and stops on stop/step at cycle end.
module beat_gen
   import beat_pkg::*;
#(
   parameter int TICKS_PER_BEAT = 1,   // legal range 1..TICKS_MAX
   parameter int CNT_W          = 8
) (
   input  logic             t3,
   input  logic             clr,
   input  logic             qd,
   input  logic             stop,
   input  logic             short,
   input  logic             long,
   input  logic             step,
   output logic             w1,
   output logic             w2,
   output logic             w3,
   output logic             running,
   output logic             beat_end,
   output logic [CNT_W-1:0] cycle_cnt,
   output beat_state_t      dbg_state
);

   localparam int TICK_W = tick_width(TICKS_PER_BEAT);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BEAT - 1);

   beat_state_t       state;
   logic [TICK_W-1:0] tick;
   logic              start;
   logic              cycle_done;

   // QD press detector; the edge is only acted on from idle.
   rise_detect u_qd_rise (
      .clk   (t3),
      .rst_n (clr),
      .d     (qd),
      .pulse (start)
   );

   // Beat outputs decode straight from the state register: glitch-free
   // and mutually exclusive.
   assign w1        = (state == B_W1);
   assign w2        = (state == B_W2);
   assign w3        = (state == B_W3);
   assign running   = (state != B_IDLE);
   assign beat_end  = running & (tick == TICK_LAST);
   assign dbg_state = state;

   // The machine cycle ends at W1 on short (short beats long when both are
   // set), at W2 unless long, and always at W3. short/long only matter on
   // the last tick of the beat they belong to.
   assign cycle_done = beat_end & (((state == B_W1) &  short) |
                                   ((state == B_W2) & ~long)  |
                                    (state == B_W3));

   // Beat sequencer: tick counting within a beat, beat advance, and the
   // cycle-end decision where stop/step are examined.
   always_ff @(posedge t3) begin
      if (!clr) begin
         state     <= B_IDLE;
         tick      <= '0;
         cycle_cnt <= '0;
      end else if (state == B_IDLE) begin
         tick <= '0;
         if (start) state <= B_W1;
      end else if (!beat_end) begin
         tick <= tick + TICK_W'(1);
      end else begin
         tick <= '0;
         if (cycle_done) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            state     <= (stop | step) ? B_IDLE : B_W1;
         end else if (state == B_W1) begin
            state <= B_W2;
         end else begin
            // Only W2 with long set reaches here.
            state <= B_W3;
         end
      end
   end

endmodule

// File: tb/tb_beat_gen.sv
// Directed bench for beat_gen: three instances share one stimulus stream.
// dut_a: 1 tick/beat, 8-bit counter; dut_b: 1 tick/beat, 2-bit counter;
// dut_c: 3 ticks/beat, 8-bit counter.
module tb_beat_gen;
   import beat_pkg::*;

   localparam logic [2:0] W_0 = 3'b000;
   localparam logic [2:0] W_1 = 3'b001;
   localparam logic [2:0] W_2 = 3'b010;
   localparam logic [2:0] W_3 = 3'b100;

   // ---------------- clock / reset ----------------
   logic t3 = 1'b0;
   always #5 t3 = ~t3;

   logic clr, qd, stop, short, long, step;

   logic [2:0]  a_w, b_w, c_w;
   logic        a_run, b_run, c_run;
   logic        a_be, b_be, c_be;
   logic [7:0]  a_cnt, c_cnt;
   logic [1:0]  b_cnt;
   beat_state_t a_st, b_st, c_st;

   beat_gen #(.TICKS_PER_BEAT(1), .CNT_W(8)) dut_a (
      .t3(t3), .clr(clr), .qd(qd), .stop(stop), .short(short), .long(long),
      .step(step), .w1(a_w[0]), .w2(a_w[1]), .w3(a_w[2]), .running(a_run),
      .beat_end(a_be), .cycle_cnt(a_cnt), .dbg_state(a_st)
   );

   beat_gen #(.TICKS_PER_BEAT(1), .CNT_W(2)) dut_b (
      .t3(t3), .clr(clr), .qd(qd), .stop(stop), .short(short), .long(long),
      .step(step), .w1(b_w[0]), .w2(b_w[1]), .w3(b_w[2]), .running(b_run),
      .beat_end(b_be), .cycle_cnt(b_cnt), .dbg_state(b_st)
   );

   beat_gen #(.TICKS_PER_BEAT(3), .CNT_W(8)) dut_c (
      .t3(t3), .clr(clr), .qd(qd), .stop(stop), .short(short), .long(long),
      .step(step), .w1(c_w[0]), .w2(c_w[1]), .w3(c_w[2]), .running(c_run),
      .beat_end(c_be), .cycle_cnt(c_cnt), .dbg_state(c_st)
   );

   // ---------------- scoreboard ----------------
   int         n_checks = 0;
   int         n_fail   = 0;
   int         exp_cnt  = 0;
   logic [2:0] exp_q[$];
   logic [2:0] exp_w;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Advance n rising edges; sample and drive 1 time unit after the edge.
   task automatic cyc(input int n);
      repeat (n) @(posedge t3);
      #1;
   endtask

   // Fresh QD press: one low cycle, then high.
   task automatic press_qd();
      qd = 1'b0;
      cyc(1);
      qd = 1'b1;
      cyc(1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      clr = 1'b0; qd = 1'b0; stop = 1'b0; short = 1'b0; long = 1'b0;
      step = 1'b0;

      // 1. Reset with qd toggling underneath.
      cyc(1);
      qd = 1'b1;
      cyc(1);
      qd = 1'b0;
      check("rst_w", a_w, W_0);
      check("rst_run", a_run, 0);
      check("rst_cnt", a_cnt, 0);
      check("rst_state_c", c_st, B_IDLE);
      check("rst_w_c", c_w, W_0);
      clr = 1'b1;
      cyc(3);
      check("post_rst_idle", a_run, 0);
      check("post_rst_state", a_st, B_IDLE);

      // 2. Short cycles: W1 continuously, one count per clock.
      short = 1'b1;
      qd = 1'b1;
      cyc(1);
      check("start_w1", a_w, W_1);
      check("start_cnt", a_cnt, 0);
      for (int i = 1; i <= 5; i++) begin
         cyc(1);
         check("short_w", a_w, W_1);
         check("short_be", a_be, 1);
         check("short_cnt", a_cnt, 32'(i));
      end
      exp_cnt = 5;

      // 3. Long cycles W1,W2,W3 then normal W1,W2 (qd stays high).
      short = 1'b0;
      long  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(W_2);
         exp_q.push_back(W_3);
         exp_q.push_back(W_1);
      end
      while (exp_q.size() > 0) begin
         cyc(1);
         exp_w = exp_q.pop_front();
         check("long_pat", a_w, exp_w);
      end
      exp_cnt += 3;
      check("long_cnt", a_cnt, exp_cnt);

      long = 1'b0;
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(W_2);
         exp_q.push_back(W_1);
      end
      while (exp_q.size() > 0) begin
         cyc(1);
         exp_w = exp_q.pop_front();
         check("norm_pat", a_w, exp_w);
      end
      exp_cnt += 2;
      check("norm_cnt", a_cnt, exp_cnt);

      // 4. Stop raised in W2 of a long cycle: W3 finishes, then idle.
      long = 1'b1;
      cyc(1);
      check("stop_pre_w2", a_w, W_2);
      stop = 1'b1;
      cyc(1);
      check("stop_w3", a_w, W_3);
      check("stop_run", a_run, 1);
      cyc(1);
      exp_cnt += 1;
      check("stop_idle", a_w, W_0);
      check("stop_run0", a_run, 0);
      check("stop_cnt", a_cnt, exp_cnt);
      stop = 1'b0;
      cyc(3);
      check("qd_held_idle", a_run, 0);
      press_qd();
      check("restart_w1", a_w, W_1);
      // Stop pulse that drops before cycle end is lost.
      stop = 1'b1;
      cyc(1);
      check("pulse_w2", a_w, W_2);
      stop = 1'b0;
      cyc(1);
      check("pulse_w3", a_w, W_3);
      cyc(1);
      exp_cnt += 1;
      check("pulse_lost_w1", a_w, W_1);
      check("pulse_lost_cnt", a_cnt, exp_cnt);

      // 5. Single-step normal cycles; dut_b counter wraps.
      step = 1'b1;
      long = 1'b0;
      cyc(2);
      exp_cnt += 1;
      check("step_idle", a_run, 0);
      check("step_cnt", a_cnt, exp_cnt);
      check("step_cnt_b", b_cnt, exp_cnt % 4);
      for (int k = 0; k < 3; k++) begin
         press_qd();
         check("step_w1", a_w, W_1);
         check("step_w1_b", b_w, W_1);
         cyc(1);
         check("step_w2", a_w, W_2);
         cyc(1);
         exp_cnt += 1;
         check("step_end", a_w, W_0);
         check("step_run_b", b_run, 0);
         check("step_cnt_a", a_cnt, exp_cnt);
         check("step_wrap_b", b_cnt, exp_cnt % 4);
      end
      check("wrap_state_b", b_st, B_IDLE);

      // Start together with stop in idle: start wins, stop ends the cycle.
      step = 1'b0;
      stop = 1'b1;
      press_qd();
      check("startstop_w1", a_w, W_1);
      cyc(1);
      check("startstop_w2", a_w, W_2);
      cyc(1);
      exp_cnt += 1;
      check("startstop_idle", a_run, 0);
      check("startstop_cnt", a_cnt, exp_cnt);
      stop = 1'b0;

      // 6. Three ticks per beat, long cycle, then reset mid-W2.
      clr = 1'b0;
      qd  = 1'b0;
      cyc(2);
      clr = 1'b1;
      long = 1'b1;
      cyc(1);
      check("c_rst_cnt", c_cnt, 0);
      qd = 1'b1;
      cyc(1);
      for (int k = 0; k < 9; k++) begin
         if (k > 0) cyc(1);
         exp_w = (k < 3) ? W_1 : ((k < 6) ? W_2 : W_3);
         check("tpb3_w", c_w, exp_w);
         check("tpb3_be", c_be, (k % 3 == 2) ? 1 : 0);
      end
      cyc(1);
      check("tpb3_wrap_w1", c_w, W_1);
      check("tpb3_cnt", c_cnt, 1);
      cyc(3);
      check("tpb3_w2_t0", c_w, W_2);
      cyc(1);
      check("tpb3_w2_t1", c_w, W_2);
      check("tpb3_w2_t1_be", c_be, 0);
      clr = 1'b0;
      cyc(1);
      check("midrst_w", c_w, W_0);
      check("midrst_run", c_run, 0);
      check("midrst_be", c_be, 0);
      check("midrst_cnt", c_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
